axi_arbiter_s2m_n: RTL
======================

# axi_arbiter_s2m_n

Parametrised slave-to-master response arbiter for the AXI interconnect, sitting on the return path of each master port. It selects one of NUM_S slaves for the read-data (R) channel and, independently, for the write-response (B) channel. The selection policy is runtime-selectable between round-robin and fixed priority. A grant is held from first presentation until its handshake completes; the optional RLAST burst lock extends the R grant to the whole burst.

## Interface
Parameters:
- NUM_S, 4, number of slave ports arbitrated; legal range 2..16.
- PTR_W, $clog2(NUM_S), round-robin pointer width; derived, not overridden.

Ports:
- AXI_CLK  in  1  interconnect clock; all state changes on its rising edge.
- AXI_RST  in  1  reset; synchronous, active-high.
- arbiter_type  in  1  0 = round-robin; 1 = fixed priority, with index 0 highest.
- BSELECT  in  NUM_S  slave i's B response is addressed to this master.
- BVALID  in  NUM_S  per-slave BVALID.
- BREADY  in  NUM_S  per-slave BREADY, as seen from the master.
- BGRANT  out  NUM_S  one-hot (or zero) B grant.
- RSELECT  in  NUM_S  slave i's R beat is addressed to this master.
- RVALID  in  NUM_S  per-slave RVALID.
- RREADY  in  NUM_S  per-slave RREADY.
- RLAST  in  NUM_S  per-slave RLAST.
- RGRANT  out  NUM_S  one-hot (or zero) R grant.
- r_busy  out  1  R channel is in HOLD.
- b_busy  out  1  B channel is in HOLD.

## Operation
The R and B channels are identical and independent, except for the RLAST lock described below.

Request and pick:
- Request vector: REQ = SELECT & VALID.
- Fixed priority: pick = the lowest set bit of REQ.
- Round-robin: pick = the first set bit of REQ at or above ptr, wrapping from NUM_S-1 to 0.
- pick = 0 when REQ = 0.

State machine, states IDLE and HOLD:
- IDLE: GRANT = pick, combinational.
  - If GRANT != 0 and there is no handshake: latch grant_reg <= GRANT and go to HOLD. Handshake means GRANT & VALID & READY is nonzero.
  - If the handshake completes in the same cycle: stay in IDLE.
- HOLD: GRANT = grant_reg, regardless of REQ, arbiter_type or higher-priority requesters. Return to IDLE on the held index's handshake.

Handshake bookkeeping:
- Round-robin pointer: on every completed handshake while arbiter_type = 0, ptr <= (granted index + 1) mod NUM_S.
- In fixed mode ptr holds its value.
- Switching arbiter_type affects only the next IDLE pick; it never affects a held grant.
- r_busy and b_busy equal (state == HOLD).

## Timing
- Grant latency: 0 cycles. GRANT follows REQ combinationally in IDLE, so a single-beat response can complete in the cycle it is first presented.
- Grant stability: once GRANT is nonzero without a handshake, it is frozen from the next edge until the handshake edge, inclusive.
- Next grant: re-arbitration happens in the cycle after the handshake edge. That cycle is IDLE again, so back-to-back grants to different slaves occur with no bubble.
- Simultaneous requests: exactly one bit of GRANT is set; non-granted VALIDs wait.
- RR wrap: with ptr = NUM_S-1 and only slave 0 requesting, slave 0 is granted.
- VALID dropping while held (an AXI violation): grant is still held; no recovery is attempted.
- Reset values, on the first edge with AXI_RST = 1: state = IDLE, grant_reg = 0, ptr = 0.
- While AXI_RST = 1, RGRANT and BGRANT are forced to 0, and r_busy and b_busy are 0.
- Reset asserted mid-burst or mid-hold aborts the hold with no further grant.

## Configuration
- AXI_ARB_S2M_RLAST_LOCK_EN defined (R channel only):
  - A completed R handshake without RLAST enters or stays in HOLD with grant_reg = the granted index.
  - HOLD exits only on a handshake with RLAST = 1.
  - The ptr update occurs only on the RLAST handshake.
  - The read burst is therefore never interleaved with another slave.
- AXI_ARB_S2M_RLAST_LOCK_EN not defined:
  - RLAST is ignored.
  - R re-arbitrates after every beat, exactly as B does.
- The B channel is unaffected by the macro.

## Test plan
- **RR fairness.** NUM_S=4, arbiter_type=0, all four slaves holding RVALID with RREADY=1 constant, single beats -> RGRANT sequence 0001, 0010, 0100, 1000, 0001, one grant per cycle.
- **Fixed priority.** arbiter_type=1, slaves 1 and 3 requesting B, BREADY=1 -> BGRANT=0010 until slave 1 drops, then 1000; ptr unchanged.
- **Hold under backpressure.** Slave 2 is granted with BREADY=0 for 3 cycles while slave 0 starts requesting -> BGRANT stays 0100 and b_busy=1 for 3 cycles. BREADY=1 completes the handshake, and the next cycle shows BGRANT=0001.
- **RLAST lock, macro defined.** Slave 1 sends a 4-beat burst while slave 0 requests -> RGRANT=0010 on all 4 beats, then 0001. Without the macro -> RGRANT alternates 0010 and 0001 (ptr moves 2, then 1, ...).
- **RR wrap.** ptr=3 after a slave-2 handshake, only slave 0 requesting -> RGRANT=0001, and ptr becomes 1 after the handshake.
- **Reset mid-hold.** Assert AXI_RST during an R HOLD of slave 3 -> RGRANT=0 and r_busy=0 while in reset. After release with slaves 0 and 3 requesting in RR mode -> RGRANT=0001.

Source files
------------

// File: rtl/axi_arbiter_s2m_n.sv
// Slave-to-master R/B response arbiter (round-robin or fixed priority, grant held to handshake).
// Optional macro AXI_ARB_S2M_RLAST_LOCK_EN locks the R grant for a whole burst, until RLAST.

module axi_arb_s2m_chan #(
   parameter int NUM_S   = 4,
   parameter int PTR_W   = $clog2(NUM_S),
   parameter bit LOCK_EN = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_arb_fixed,
   input  logic [NUM_S-1:0] i_select,
   input  logic [NUM_S-1:0] i_valid,
   input  logic [NUM_S-1:0] i_ready,
   input  logic [NUM_S-1:0] i_last,
   output logic [NUM_S-1:0] o_grant,
   output logic             o_busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [NUM_S-1:0] r_grant;
   logic [NUM_S-1:0] w_grant_nxt;
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_nxt;

   logic [NUM_S-1:0] w_req;
   logic [NUM_S-1:0] w_pick;
   logic [NUM_S-1:0] w_grant;
   logic [PTR_W-1:0] w_start;
   logic [PTR_W-1:0] w_cand;
   logic [PTR_W-1:0] w_gidx;
   logic             w_found;
   logic             w_hit;
   logic             w_hs;
   logic             w_last;
   logic             w_done;

   // Request pick: scan from the RR pointer (or from 0 in fixed mode) with wrap, first hit wins.
   always_comb begin
      w_req   = i_select & i_valid;
      w_pick  = '0;
      w_found = 1'b0;
      w_hit   = 1'b0;
      w_cand  = '0;
      w_start = i_arb_fixed ? '0 : r_ptr;
      for (int k = 0; k < NUM_S; k++) begin
         w_cand         = PTR_W'((int'(w_start) + k) % NUM_S);
         w_hit          = ~w_found & w_req[w_cand];
         w_pick[w_cand] = w_pick[w_cand] | w_hit;
         w_found        = w_found | w_hit;
      end
   end

   // Effective grant, handshake detection and its index.
   always_comb begin
      w_grant = (r_state == ST_HOLD) ? r_grant : w_pick;
      w_hs    = |(w_grant & i_valid & i_ready);
      w_last  = LOCK_EN ? |(w_grant & i_last) : 1'b1;
      w_done  = w_hs & w_last;
      w_gidx  = '0;
      for (int i = 0; i < NUM_S; i++) begin
         w_gidx = w_gidx | (w_grant[i] ? PTR_W'(i) : '0);
      end
   end

   // Next-state logic; a non-final locked beat keeps (or enters) HOLD on the same slave.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if ((|w_grant) && !w_done) begin
               w_state_nxt = ST_HOLD;
               w_grant_nxt = w_grant;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (w_done) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_done && !i_arb_fixed) begin
         w_ptr_nxt = PTR_W'((int'(w_gidx) + 1) % NUM_S);
      end else begin
         w_ptr_nxt = r_ptr;
      end
   end

   // State, held grant and round-robin pointer registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Grant is zero-latency in IDLE, so it cannot be registered; reset masks it.
   assign o_grant = i_rst ? '0 : w_grant;
   assign o_busy  = ~i_rst & (r_state == ST_HOLD);

endmodule

module axi_arbiter_s2m_n #(
   parameter int NUM_S = 4,
   parameter int PTR_W = $clog2(NUM_S)
) (
   input  logic             AXI_CLK,
   input  logic             AXI_RST,
   input  logic             arbiter_type,
   input  logic [NUM_S-1:0] BSELECT,
   input  logic [NUM_S-1:0] BVALID,
   input  logic [NUM_S-1:0] BREADY,
   output logic [NUM_S-1:0] BGRANT,
   input  logic [NUM_S-1:0] RSELECT,
   input  logic [NUM_S-1:0] RVALID,
   input  logic [NUM_S-1:0] RREADY,
   input  logic [NUM_S-1:0] RLAST,
   output logic [NUM_S-1:0] RGRANT,
   output logic             r_busy,
   output logic             b_busy
);

`ifdef AXI_ARB_S2M_RLAST_LOCK_EN
   localparam bit R_LOCK_EN = 1'b1;
`else
   localparam bit R_LOCK_EN = 1'b0;
`endif

   logic [NUM_S-1:0] w_b_last;

   assign w_b_last = '0;

   axi_arb_s2m_chan #(
      .NUM_S   (NUM_S),
      .PTR_W   (PTR_W),
      .LOCK_EN (R_LOCK_EN)
   ) u_r_chan (
      .i_clk       (AXI_CLK),
      .i_rst       (AXI_RST),
      .i_arb_fixed (arbiter_type),
      .i_select    (RSELECT),
      .i_valid     (RVALID),
      .i_ready     (RREADY),
      .i_last      (RLAST),
      .o_grant     (RGRANT),
      .o_busy      (r_busy)
   );

   axi_arb_s2m_chan #(
      .NUM_S   (NUM_S),
      .PTR_W   (PTR_W),
      .LOCK_EN (1'b0)
   ) u_b_chan (
      .i_clk       (AXI_CLK),
      .i_rst       (AXI_RST),
      .i_arb_fixed (arbiter_type),
      .i_select    (BSELECT),
      .i_valid     (BVALID),
      .i_ready     (BREADY),
      .i_last      (w_b_last),
      .o_grant     (BGRANT),
      .o_busy      (b_busy)
   );

endmodule
